// File: rtl/pipe_stage_buf.sv
// rtl/pipe_stage_buf.sv - parametrised inter-stage pipeline buffer with optional 2-entry skid
module pipe_stage_buf #(
  parameter int unsigned       WIDTH  = 116,
  parameter bit                SKID   = 1'b1,
  parameter logic [WIDTH-1:0]  BUBBLE = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [1:0]        occupancy,
  output logic [31:0]       stall_cycles
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_fire;
  logic             out_fire;

  // With the skid, in_ready comes from state alone; without it, a full
  // register can still take a beat in the same cycle the old one leaves.
  generate
    if (SKID) begin : g_skid
      assign in_ready = !reset && (state != FULL);
    end else begin : g_single
      assign in_ready = !reset && ((state == EMPTY) || out_ready);
    end
  endgenerate

  assign out_valid = (state != EMPTY);
  assign out_data  = main_q;
  assign occupancy = state;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= EMPTY;
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
    end else if (flush) begin
      state  <= EMPTY;
      main_q <= BUBBLE;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state  <= ONE;
            main_q <= in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            state  <= FULL;
            skid_q <= in_data;
          end else if (out_fire) begin
            state  <= EMPTY;
            main_q <= BUBBLE;
          end
        end
        FULL: begin
          if (out_fire) begin
            state  <= ONE;
            main_q <= skid_q;
          end
        end
        default: begin
          state  <= EMPTY;
          main_q <= BUBBLE;
        end
      endcase
    end
  end

  // Counts upstream back-pressure; flush deliberately leaves it alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_cycles <= 32'd0;
    end else if (in_valid && !in_ready && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule
